// File: rtl/mpmc11_to_recover.sv
// -----------------------------------------------------------------------------
// mpmc11_to_recover
//
// Purpose:
//   Watches the mpmc11 controller's state-dwell timeout count. When the
//   controller sits in a non-IDLE state long enough for to_cnt to hit
//   TO_LIMIT, this block asks the controller FSM to abort (abort_req/abort_ack
//   handshake), then waits for the controller to come back to IDLE. Failed
//   recoveries (no ack in time, or no return to IDLE in time) are counted.
//   After RETRY_MAX consecutive failures a sticky fault is raised and the
//   block stops issuing aborts until software clears it with fault_clr.
//
// Optional build macro:
//   MPMC11_TO_IRQ_EN - when defined, irq is a registered timeout interrupt.
//                      When undefined, irq is tied to 0 and no logic exists.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   state      in   current controller state (mpmc11_state_t)
//   to_cnt     in   16-bit dwell count from the timeout counter
//   abort_ack  in   controller accepted the abort (pulse or level)
//   fault_clr  in   clears fault and retry_cnt (also leaves FAULT)
//   abort_req  out  abort request to the controller FSM
//   fault      out  sticky recovery-failure flag
//   to_state   out  controller state captured at the last timeout
//   to_total   out  8-bit saturating count of accepted timeouts
//   retry_cnt  out  4-bit count of consecutive failed recoveries
//   irq        out  timeout interrupt (0 unless MPMC11_TO_IRQ_EN)
// -----------------------------------------------------------------------------

package mpmc11_pkg;

  // Controller state encoding shared with the mpmc11 controller FSM.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACTIVATE  = 3'd1,
    READ      = 3'd2,
    WRITE     = 3'd3,
    PRECHARGE = 3'd4,
    REFRESH   = 3'd5
  } mpmc11_state_t;

endpackage : mpmc11_pkg

module mpmc11_to_recover
  import mpmc11_pkg::*;
#(
  parameter int unsigned TO_LIMIT  = 512,
  parameter int unsigned ACK_WAIT  = 16,
  parameter int unsigned IDLE_WAIT = 64,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  mpmc11_state_t state,
  input  logic [15:0]   to_cnt,
  input  logic          abort_ack,
  input  logic          fault_clr,
  output logic          abort_req,
  output logic          fault,
  output mpmc11_state_t to_state,
  output logic [7:0]    to_total,
  output logic [3:0]    retry_cnt,
  output logic          irq
);

  // ---------------------------------------------------------------------------
  // Parameter legality. An out-of-range value instantiates a module that does
  // not exist, so elaboration stops instead of building a broken counter.
  // ---------------------------------------------------------------------------
  generate
    if ((TO_LIMIT < 1) || (TO_LIMIT > 65535) ||
        (ACK_WAIT < 1) || (ACK_WAIT > 255) ||
        (IDLE_WAIT < 1) || (IDLE_WAIT > 255) ||
        (RETRY_MAX < 1) || (RETRY_MAX > 15)) begin : g_bad_param
      mpmc11_to_recover_illegal_parameter u_illegal_parameter ();
    end
  endgenerate

  // Parameters narrowed to the widths of the signals they are compared with.
  localparam logic [15:0] TO_LIMIT_W = 16'(TO_LIMIT);
  localparam logic [7:0]  ACK_LAST   = 8'(ACK_WAIT - 1);
  localparam logic [7:0]  IDLE_LAST  = 8'(IDLE_WAIT - 1);
  localparam logic [3:0]  RETRY_LIM  = 4'(RETRY_MAX);

  // Recovery sequencer states.
  typedef enum logic [1:0] {
    MON   = 2'd0,   // monitoring to_cnt for a timeout
    ABORT = 2'd1,   // abort_req held, waiting for abort_ack
    DRAIN = 2'd2,   // ack seen, waiting for the controller to reach IDLE
    FAULT = 2'd3    // too many failures, parked until fault_clr
  } rec_state_t;

  rec_state_t    fsm_reg,       fsm_next;
  logic [7:0]    wait_reg,      wait_next;
  logic          abort_req_reg, abort_req_next;
  logic          fault_reg,     fault_next;
  mpmc11_state_t to_state_reg,  to_state_next;
  logic [7:0]    to_total_reg,  to_total_next;
  logic [3:0]    retry_reg,     retry_next;

  // ---------------------------------------------------------------------------
  // Event decode. Each event is qualified by the sequencer state so that
  // timeouts and acks outside their own phase are ignored.
  // ---------------------------------------------------------------------------
  logic       timeout_evt;
  logic       ack_take;
  logic       ack_expire;
  logic       drain_ok;
  logic       drain_expire;
  logic       fail_evt;
  logic [3:0] retry_inc;
  logic       fail_to_fault;

  assign timeout_evt  = (fsm_reg == MON) && (state != IDLE) && (to_cnt == TO_LIMIT_W);
  assign ack_take     = (fsm_reg == ABORT) && abort_ack;
  // An ack on the final wait cycle beats the expiry.
  assign ack_expire   = (fsm_reg == ABORT) && !abort_ack && (wait_reg == ACK_LAST);
  assign drain_ok     = (fsm_reg == DRAIN) && (state == IDLE);
  // Reaching IDLE on the final wait cycle beats the expiry.
  assign drain_expire = (fsm_reg == DRAIN) && (state != IDLE) && (wait_reg == IDLE_LAST);
  assign fail_evt     = ack_expire || drain_expire;
  // retry_reg is always below RETRY_LIM while recoveries are running (reaching
  // the limit parks the sequencer in FAULT), so this increment cannot wrap.
  assign retry_inc     = retry_reg + 4'd1;
  assign fail_to_fault = fail_evt && (retry_inc >= RETRY_LIM);

  // ---------------------------------------------------------------------------
  // State register (all sequential state lives here).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= MON;
      wait_reg      <= 8'd0;
      abort_req_reg <= 1'b0;
      fault_reg     <= 1'b0;
      to_state_reg  <= IDLE;
      to_total_reg  <= 8'd0;
      retry_reg     <= 4'd0;
    end else begin
      fsm_reg       <= fsm_next;
      wait_reg      <= wait_next;
      abort_req_reg <= abort_req_next;
      fault_reg     <= fault_next;
      to_state_reg  <= to_state_next;
      to_total_reg  <= to_total_next;
      retry_reg     <= retry_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_next = fsm_reg;
    unique case (fsm_reg)
      MON: begin
        if (timeout_evt) begin
          fsm_next = ABORT;
        end
      end
      ABORT: begin
        if (ack_take) begin
          fsm_next = DRAIN;
        end else if (ack_expire) begin
          fsm_next = fail_to_fault ? FAULT : MON;
        end
      end
      DRAIN: begin
        if (drain_ok) begin
          fsm_next = MON;
        end else if (drain_expire) begin
          fsm_next = fail_to_fault ? FAULT : MON;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          fsm_next = MON;
        end
      end
      default: fsm_next = MON;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values.
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_next     = wait_reg;
    to_state_next = to_state_reg;
    to_total_next = to_total_reg;
    retry_next    = retry_reg;
    fault_next    = fault_reg;

    // The request is simply "the sequencer will be in ABORT next cycle": it
    // rises with the timeout and falls on ack, expiry, or entry to FAULT.
    abort_req_next = (fsm_next == ABORT);

    unique case (fsm_reg)
      MON: begin
        if (timeout_evt) begin
          wait_next     = 8'd0;
          to_state_next = state;
          if (to_total_reg != 8'hFF) begin
            to_total_next = to_total_reg + 8'd1;
          end
        end
      end
      ABORT: begin
        if (ack_take) begin
          wait_next = 8'd0;
        end else if (!ack_expire) begin
          wait_next = wait_reg + 8'd1;
        end
      end
      DRAIN: begin
        if (!drain_ok && !drain_expire) begin
          wait_next = wait_reg + 8'd1;
        end
      end
      FAULT: begin
        wait_next = wait_reg;
      end
      default: wait_next = 8'd0;
    endcase

    // retry_cnt: a failure on this cycle takes precedence over a clear, so a
    // failed recovery is never lost to a coincident fault_clr.
    if (fail_evt) begin
      retry_next = retry_inc;
    end else if (drain_ok || fault_clr) begin
      retry_next = 4'd0;
    end

    if (fail_to_fault) begin
      fault_next = 1'b1;
    end else if (fault_clr) begin
      fault_next = 1'b0;
    end
  end

  assign abort_req = abort_req_reg;
  assign fault     = fault_reg;
  assign to_state  = to_state_reg;
  assign to_total  = to_total_reg;
  assign retry_cnt = retry_reg;

  // ---------------------------------------------------------------------------
  // Optional timeout interrupt.
  // ---------------------------------------------------------------------------
`ifdef MPMC11_TO_IRQ_EN
  logic irq_reg, irq_next;
  logic irq_set, irq_clr;

  assign irq_set = timeout_evt || fail_to_fault;
  assign irq_clr = fault_clr || ack_take;

  // Set wins over clear when both happen on the same edge.
  always_comb begin
    irq_next = irq_reg;
    if (irq_set) begin
      irq_next = 1'b1;
    end else if (irq_clr) begin
      irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= irq_next;
    end
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

endmodule : mpmc11_to_recover

// File: tb/tb_mpmc11_to_recover.sv
// -----------------------------------------------------------------------------
// tb_mpmc11_to_recover
//
// Drives recovery episodes (timeout, optional ack after k cycles, optional
// return to IDLE after j cycles). For each episode the expected abort pulse
// (length, captured state, timeout total) is pushed into a queue; a monitor
// measures every abort_req pulse and pops/compares. The episode outcome is
// predicted from the behavioural rules: success clears the retry count,
// failure increments it, and reaching RETRY_MAX latches the fault.
// -----------------------------------------------------------------------------
module tb_mpmc11_to_recover;
  import mpmc11_pkg::*;

  localparam int TO_LIMIT  = 512;
  localparam int ACK_WAIT  = 16;
  localparam int IDLE_WAIT = 64;
  localparam int RETRY_MAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  mpmc11_state_t state_i;
  logic [15:0]   to_cnt_i;
  logic          abort_ack_i;
  logic          fault_clr_i;
  logic          abort_req;
  logic          fault;
  mpmc11_state_t to_state;
  logic [7:0]    to_total;
  logic [3:0]    retry_cnt;
  logic          irq;

  mpmc11_to_recover #(
    .TO_LIMIT (TO_LIMIT),
    .ACK_WAIT (ACK_WAIT),
    .IDLE_WAIT(IDLE_WAIT),
    .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state_i),
    .to_cnt   (to_cnt_i),
    .abort_ack(abort_ack_i),
    .fault_clr(fault_clr_i),
    .abort_req(abort_req),
    .fault    (fault),
    .to_state (to_state),
    .to_total (to_total),
    .retry_cnt(retry_cnt),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Expected abort pulse.
  typedef struct {
    mpmc11_state_t st;
    int            total;
    int            len;
  } pulse_t;

  pulse_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_total;
  int m_retry;
  bit m_fault;
  bit m_irq;

  function automatic void check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int exp_irq();
`ifdef MPMC11_TO_IRQ_EN
    return int'(m_irq);
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_total = 0;
    m_retry = 0;
    m_fault = 0;
    m_irq   = 0;
  endtask

  task automatic check_status(string tag);
    check({tag, "_abort_req"}, int'(abort_req), 0);
    check({tag, "_retry_cnt"}, int'(retry_cnt), m_retry);
    check({tag, "_fault"}, int'(fault), int'(m_fault));
    check({tag, "_irq"}, int'(irq), exp_irq());
  endtask

  // One recovery episode: timeout in state s; ack on the k-th ABORT cycle
  // (0 = never); IDLE on the jd-th DRAIN cycle (0 = never). clr asserts
  // fault_clr on the timeout edge as well.
  task automatic run_episode(mpmc11_state_t s, int k, int jd, bit clr);
    bit ok;
    if (m_fault) begin
      state_i  = s;
      to_cnt_i = 16'(TO_LIMIT);
      tick();
      to_cnt_i = 16'd0;
      state_i  = IDLE;
      tick();
      check("fault_ignore_req", int'(abort_req), 0);
      check("fault_ignore_total", int'(to_total), m_total);
      check("fault_hold", int'(fault), 1);
      $display("[TB] episode state=%0d ignored in fault, to_total=%0d", int'(s), to_total);
      return;
    end

    state_i     = s;
    to_cnt_i    = 16'(TO_LIMIT);
    abort_ack_i = 1'b0;
    fault_clr_i = clr;
    m_total     = (m_total < 255) ? m_total + 1 : 255;
    m_irq       = 1'b1;
    if (clr) m_retry = 0;
    exp_q.push_back('{st: s, total: m_total, len: (k > 0) ? k : ACK_WAIT});
    tick();
    fault_clr_i = 1'b0;
    check("req_latency", int'(abort_req), 1);
    check("irq_on_timeout", int'(irq), exp_irq());
    if (clr) check("clr_retry", int'(retry_cnt), 0);

    // Timeouts seen while recovering must be ignored.
    to_cnt_i = ($urandom_range(0, 1) != 0) ? 16'(TO_LIMIT) : 16'(TO_LIMIT - 1);

    for (int i = 1; i <= ACK_WAIT; i++) begin
      abort_ack_i = (i == k);
      tick();
      if (i == k) break;
    end
    abort_ack_i = 1'b0;
    check("req_drop", int'(abort_req), 0);

    ok = 1'b0;
    if (k > 0) begin
      m_irq = 1'b0;
      for (int j = 1; j <= IDLE_WAIT; j++) begin
        state_i = (j == jd) ? IDLE : s;
        tick();
        if (j == jd) break;
      end
      ok = (jd > 0);
    end

    if (ok) begin
      m_retry = 0;
    end else begin
      m_retry++;
      if (m_retry >= RETRY_MAX) begin
        m_fault = 1'b1;
        m_irq   = 1'b1;
      end
    end

    // Quiet cycle; a stray ack here (outside ABORT) must have no effect.
    state_i     = IDLE;
    to_cnt_i    = 16'd0;
    abort_ack_i = 1'($urandom_range(0, 1));
    tick();
    abort_ack_i = 1'b0;
    check_status("episode");
    $display("[TB] episode state=%0d k=%0d jd=%0d -> retry_cnt=%0d fault=%0d to_total=%0d irq=%0d",
             int'(s), k, jd, retry_cnt, fault, to_total, irq);
  endtask

  task automatic do_clear();
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    m_fault = 1'b0;
    m_retry = 0;
    m_irq   = 1'b0;
    check_status("clear");
    $display("[TB] fault_clr -> fault=%0d retry_cnt=%0d irq=%0d", fault, retry_cnt, irq);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: measures each abort_req pulse and compares with the queue.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit     in_pulse;
    int     len;
    int     cap_st;
    int     cap_tot;
    pulse_t e;
    in_pulse = 1'b0;
    len      = 0;
    cap_st   = 0;
    cap_tot  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pulse = 1'b0;
        len      = 0;
      end else if (abort_req) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          len      = 1;
          cap_st   = int'(to_state);
          cap_tot  = int'(to_total);
        end else begin
          len++;
        end
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_abort: got pulse of %0d cycles, expected none", len);
        end else begin
          e = exp_q.pop_front();
          check("pulse_len", len, e.len);
          check("to_state", cap_st, int'(e.st));
          check("to_total", cap_tot, e.total);
          $display("[TB] pulse len=%0d to_state=%0d to_total=%0d", len, cap_st, cap_tot);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  initial begin : driver
    int kind;
    int k;
    int jd;
    mpmc11_state_t s;

    rst_n       = 1'b0;
    state_i     = IDLE;
    to_cnt_i    = 16'd0;
    abort_ack_i = 1'b0;
    fault_clr_i = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_abort_req", int'(abort_req), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_to_state", int'(to_state), int'(IDLE));
    check("rst_to_total", int'(to_total), 0);
    check("rst_retry_cnt", int'(retry_cnt), 0);
    check("rst_irq", int'(irq), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Ramp to the limit in READ, ack immediately, IDLE three cycles later.
    state_i = READ;
    for (int v = TO_LIMIT - 4; v < TO_LIMIT; v++) begin
      to_cnt_i = 16'(v);
      tick();
      check("ramp_no_req", int'(abort_req), 0);
    end
    run_episode(READ, 1, 3, 1'b0);

    // Ack never arrives: three failures latch the fault.
    run_episode(WRITE, 0, 0, 1'b0);
    run_episode(WRITE, 0, 0, 1'b0);
    run_episode(WRITE, 0, 0, 1'b0);
    run_episode(READ, 1, 1, 1'b0);
    do_clear();

    // Ack given but IDLE never reached; then ack on the expiry cycle and IDLE
    // on the expiry cycle (both must count as success).
    run_episode(WRITE, 5, 0, 1'b0);
    run_episode(WRITE, ACK_WAIT, 2, 1'b0);
    run_episode(REFRESH, 3, IDLE_WAIT, 1'b0);
    // fault_clr coinciding with a timeout: retry cleared, irq set wins.
    run_episode(ACTIVATE, 0, 0, 1'b0);
    run_episode(PRECHARGE, 2, 1, 1'b1);

    // IDLE with to_cnt at the limit: no abort.
    state_i  = IDLE;
    to_cnt_i = 16'(TO_LIMIT);
    repeat (5) tick();
    check("idle_no_req", int'(abort_req), 0);
    check("idle_no_total", int'(to_total), m_total);
    to_cnt_i = 16'd0;
    tick();

    // Reset in the middle of ABORT.
    state_i  = READ;
    to_cnt_i = 16'(TO_LIMIT);
    tick();
    check("pre_rst_req", int'(abort_req), 1);
    to_cnt_i = 16'd0;
    state_i  = IDLE;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_abort_req", int'(abort_req), 0);
    check("arst_fault", int'(fault), 0);
    check("arst_to_state", int'(to_state), int'(IDLE));
    check("arst_to_total", int'(to_total), 0);
    check("arst_retry_cnt", int'(retry_cnt), 0);
    check("arst_irq", int'(irq), 0);
    $display("[TB] async reset mid-abort -> abort_req=%0d to_total=%0d", abort_req, to_total);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Saturation of the timeout total.
    for (int n = 0; n < 300; n++) begin
      run_episode(mpmc11_state_t'(3'($urandom_range(1, 5))), 1, 1, 1'b0);
    end
    check("to_total_sat", int'(to_total), 255);

    // Randomized mix.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      s    = mpmc11_state_t'(3'($urandom_range(1, 5)));
      if (kind <= 5) begin
        k  = $urandom_range(1, ACK_WAIT);
        jd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, IDLE_WAIT) : $urandom_range(1, 4);
        run_episode(s, k, jd, 1'($urandom_range(0, 1)));
      end else if (kind <= 7) begin
        run_episode(s, 0, 0, 1'b0);
      end else if (kind == 8) begin
        run_episode(s, $urandom_range(1, ACK_WAIT), 0, 1'b0);
      end else begin
        do_clear();
      end
    end

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mpmc11_to_recover

// File: doc/mpmc11_to_recover.md
Name: mpmc11_to_recover

Overview:
Consumer of the mpmc11 controller's state-dwell timeout count (to_cnt).
- Detects a controller stuck in a non-IDLE state and requests an abort from the controller state machine over a req/ack handshake.
- Waits for the controller to return to IDLE, counts retries, and latches a sticky fault when recovery keeps failing.
- Sits beside the controller FSM; its outputs feed the FSM abort input and the status register block.

Parameters:
TO_LIMIT, 512, to_cnt value treated as a timeout; legal range 1..65535.
ACK_WAIT, 16, max cycles abort_req is held waiting for abort_ack; legal range 1..255.
IDLE_WAIT, 64, max cycles allowed after ack for state to reach IDLE; legal range 1..255.
RETRY_MAX, 3, consecutive failed recoveries before fault; legal range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
state  in  mpmc11_state_t  current controller state
to_cnt  in  16  dwell count from the timeout counter
abort_ack  in  1  controller accepted the abort (single-cycle pulse or level)
fault_clr  in  1  clears fault and retry_cnt
abort_req  out  1  abort request to the controller FSM
fault  out  1  sticky: recovery failed RETRY_MAX times in a row
to_state  out  mpmc11_state_t  state captured at the last timeout
to_total  out  8  saturating count of timeout events
retry_cnt  out  4  consecutive failed recoveries
irq  out  1  timeout interrupt; present only with the optional feature

Behaviour:
- Reset (rst_n low, asynchronous):
  - abort_req=0, fault=0, to_state=IDLE, to_total=0, retry_cnt=0, irq=0.
  - FSM=MON; internal wait counter=0.
- Timeout event: in MON, state!=IDLE and to_cnt==TO_LIMIT, sampled at a clk edge.
- FSM MON:
  - On a timeout event, capture to_state<=state and to_total<=to_total+1 (saturates at 255).
  - In the same edge, set abort_req<=1, clear the wait counter, and go to ABORT.
  - Timeout events are ignored in every other FSM state.
- FSM ABORT:
  - abort_req stays 1.
  - On abort_ack=1: abort_req<=0, clear the wait counter, go to DRAIN.
  - If the wait counter reaches ACK_WAIT-1 with no ack: abort_req<=0 and count a failure.
  - The wait counter increments every cycle otherwise.
- FSM DRAIN:
  - If state==IDLE: retry_cnt<=0 and go to MON.
  - If the wait counter reaches IDLE_WAIT-1 first: count a failure.
- Failure:
  - retry_cnt<=retry_cnt+1.
  - If the new value >= RETRY_MAX: fault<=1 and go to FAULT.
  - Otherwise go to MON, and a fresh timeout triggers another abort.
- FSM FAULT:
  - abort_req held 0.
  - Stays in FAULT until fault_clr=1; then fault<=0, retry_cnt<=0, go to MON.
- fault_clr in any other FSM state: clears fault and retry_cnt only; FSM unaffected.
- Simultaneous events:
  - abort_ack and ACK_WAIT expiry on the same cycle: the ack wins.
  - state==IDLE and IDLE_WAIT expiry on the same cycle: IDLE wins.
- abort_ack outside ABORT is ignored.
- to_total and to_state are never cleared by fault_clr; only reset clears them.
- Latency:
  - Timeout event to abort_req=1: 1 cycle.
  - abort_ack to abort_req=0: 1 cycle.
- Widths: wait counter is 8 bits; retry_cnt is 4 bits; all comparisons are unsigned.

Optional Feature:
MPMC11_TO_IRQ_EN
- Defined:
  - irq<=1 on every timeout event accepted in MON, and on entry to FAULT.
  - irq<=0 on fault_clr or when abort_ack is accepted.
  - Set wins over clear on the same cycle.
- Undefined: irq is tied to 0 and no irq logic is built.

Test Plan:
1. Reset mid-ABORT (abort_req=1) -> all outputs return to reset values immediately, asynchronously; FSM=MON.
2. state=READ, to_cnt ramps to 512 -> abort_req=1 next cycle, to_state=READ, to_total=1; abort_ack pulse -> abort_req=0; state=IDLE 3 cycles later -> retry_cnt=0, FSM=MON.
3. Timeout with abort_ack never asserted -> abort_req drops after 16 cycles, retry_cnt=1; two more identical timeouts -> retry_cnt=3, fault=1, later timeouts ignored; fault_clr -> fault=0, retry_cnt=0.
4. Ack given, but state stays WRITE for 64 cycles -> failure counted, retry_cnt=1; ack and expiry on the same cycle -> DRAIN entered, no failure.
5. state=IDLE with to_cnt forced to 512 -> no abort; 300 timeout events with successful recovery -> to_total saturates at 255.
6. With MPMC11_TO_IRQ_EN: timeout -> irq=1; ack -> irq=0; entry to FAULT -> irq=1 until fault_clr. Without the macro: irq constant 0.
